// File: rtl/mem_bus_master.sv
// Initiator for the shared 8-bit RAM bus. Takes one read or write command
// at a time from the core, runs a single-cycle bus access, returns read data
// over a response port, then idles the bus for TURNAROUND cycles (0..3) so
// the master and the RAM never drive bus_data in the same cycle.
//
// Handshakes: a transfer happens on a rising clk edge where valid & ready are
// both high. The producer holds its payload stable while valid & !ready, and
// ready never depends on valid. cmd_ready is low while rst is high, so a
// command offered during reset is never counted as accepted.
module mem_bus_master #(
  parameter int unsigned TURNAROUND = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_we,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  inout  wire  [7:0] bus_data,
  output logic       bus_we,
  output logic       bus_oe,
  output logic [7:0] bus_addr,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_RD   = 3'd2,
    S_RSP  = 3'd3,
    S_TURN = 3'd4
  } state_e;

  // TURN is entered with the count of remaining cycles after the first one.
  localparam logic [1:0] TURN_LOAD = (TURNAROUND == 0) ? 2'd0 : 2'(TURNAROUND - 1);

  state_e     state_q;
  logic [1:0] turn_cnt_q;
  logic [7:0] addr_q;
  logic [7:0] wdata_q;
  logic [7:0] rdata_q;
  logic       we_q;
  logic       oe_q;
  logic       rsp_valid_q;

  // Bus sequencing FSM; every bus and response output is a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      turn_cnt_q  <= 2'd0;
      addr_q      <= 8'd0;
      wdata_q     <= 8'd0;
      rdata_q     <= 8'd0;
      we_q        <= 1'b0;
      oe_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            if (cmd_we) begin
              state_q <= S_WR;
              we_q    <= 1'b1;
            end else begin
              state_q <= S_RD;
              oe_q    <= 1'b1;
            end
          end
        end
        S_WR: begin
          // The RAM captures the write at this closing edge.
          we_q       <= 1'b0;
          turn_cnt_q <= TURN_LOAD;
          state_q    <= (TURNAROUND == 0) ? S_IDLE : S_TURN;
        end
        S_RD: begin
          oe_q        <= 1'b0;
          rdata_q     <= bus_data;
          rsp_valid_q <= 1'b1;
          state_q     <= S_RSP;
        end
        S_RSP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            turn_cnt_q  <= TURN_LOAD;
            state_q     <= (TURNAROUND == 0) ? S_IDLE : S_TURN;
          end
        end
        S_TURN: begin
          if (turn_cnt_q == 2'd0) begin
            state_q <= S_IDLE;
          end else begin
            turn_cnt_q <= turn_cnt_q - 2'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          we_q    <= 1'b0;
          oe_q    <= 1'b0;
        end
      endcase
    end
  end

  // Output decode: the data bus is driven only while the write strobe is up.
  assign bus_data  = we_q ? wdata_q : 8'bz;
  assign bus_we    = we_q;
  assign bus_oe    = oe_q;
  assign bus_addr  = addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign cmd_ready = (state_q == S_IDLE) && !rst;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: one instance with TURNAROUND=1 carries the main
// tests, a second with TURNAROUND=0 checks back-to-back write throughput.
// Each bus has a RAM model plus a probe driver that puts a random pattern on
// the bus whenever neither strobe is up, so a master that fails to release
// the bus corrupts the probe value.
module tb_mem_bus_master;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT with TURNAROUND=1 ----------------
  logic       cmd_valid, cmd_ready, cmd_we, rsp_valid, rsp_ready, busy;
  logic       bus_we, bus_oe;
  logic [7:0] cmd_addr, cmd_wdata, rsp_rdata, bus_addr;
  logic [2:0] dbg_state;
  wire  [7:0] bus_data;

  mem_bus_master #(.TURNAROUND(1)) u_dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .busy(busy), .bus_data(bus_data), .bus_we(bus_we), .bus_oe(bus_oe),
    .bus_addr(bus_addr), .dbg_state(dbg_state)
  );

  // ---------------- DUT with TURNAROUND=0 ----------------
  logic       z_cmd_valid, z_cmd_ready, z_cmd_we, z_rsp_valid, z_rsp_ready, z_busy;
  logic       z_bus_we, z_bus_oe;
  logic [7:0] z_cmd_addr, z_cmd_wdata, z_rsp_rdata, z_bus_addr;
  logic [2:0] z_dbg_state;
  wire  [7:0] z_bus_data;

  mem_bus_master #(.TURNAROUND(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .cmd_valid(z_cmd_valid), .cmd_ready(z_cmd_ready), .cmd_we(z_cmd_we),
    .cmd_addr(z_cmd_addr), .cmd_wdata(z_cmd_wdata),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata),
    .busy(z_busy), .bus_data(z_bus_data), .bus_we(z_bus_we), .bus_oe(z_bus_oe),
    .bus_addr(z_bus_addr), .dbg_state(z_dbg_state)
  );

  // ---------------- RAM models and bus probes ----------------
  logic [7:0] ram1 [0:255];
  logic [7:0] ram0 [0:255];
  logic [7:0] probe1, probe0;

  assign bus_data   = bus_oe ? ram1[bus_addr] : 8'bz;
  assign bus_data   = (!bus_we && !bus_oe) ? probe1 : 8'bz;
  assign z_bus_data = z_bus_oe ? ram0[z_bus_addr] : 8'bz;
  assign z_bus_data = (!z_bus_we && !z_bus_oe) ? probe0 : 8'bz;

  always @(posedge clk) begin
    if (bus_we)   ram1[bus_addr]   <= bus_data;
    if (z_bus_we) ram0[z_bus_addr] <= z_bus_data;
    probe1 <= 8'($urandom);
    probe0 <= 8'($urandom);
  end

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] ref_mem [0:255];
  logic [7:0] exp_q[$];
  logic       mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycle-by-cycle protocol monitor on both instances.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("we_oe_exclusive", {31'd0, bus_we & bus_oe}, 32'd0);
      chk("ready_valid_exclusive", {31'd0, cmd_ready & rsp_valid}, 32'd0);
      chk("ta0_we_oe_exclusive", {31'd0, z_bus_we & z_bus_oe}, 32'd0);
      if (!rst) begin
        chk("busy_vs_ready", {31'd0, busy}, {31'd0, !cmd_ready});
        chk("ta0_busy_vs_ready", {31'd0, z_busy}, {31'd0, !z_cmd_ready});
      end
      if (!bus_we && !bus_oe) chk("bus_released", {24'd0, bus_data}, {24'd0, probe1});
      if (!z_bus_we && !z_bus_oe) chk("ta0_bus_released", {24'd0, z_bus_data}, {24'd0, probe0});
    end
  end

  // ---------------- driver tasks ----------------
  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic send_cmd(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                          output int acc);
    logic ok = 1'b0;
    logic rdy;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdata;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk); rdy = cmd_ready;
      @(posedge clk); if (rdy) ok = 1'b1;
    end
    #1;
    acc = cyc;
    cmd_valid = 1'b0;
    chk("cmd_accept", {31'd0, ok}, 32'd1);
    if (ok) begin
      if (we) ref_mem[addr] = wdata;
      else    exp_q.push_back(ref_mem[addr]);
    end
  endtask

  task automatic recv_rsp(input int hold, output logic [7:0] data);
    logic ok = 1'b0;
    int   n = 0;
    logic [7:0] exp;
    data = 8'd0;
    rsp_ready = (hold == 0);
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (rsp_valid) begin
        if (n >= hold) begin
          rsp_ready = 1'b1;
          data = rsp_rdata;
          ok = 1'b1;
        end
        n++;
      end
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_arrival", {31'd0, ok}, 32'd1);
    if (ok) begin
      chk("exp_q_nonempty", exp_q.size(), 32'(exp_q.size() > 0 ? exp_q.size() : 1));
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
      chk("rsp_rdata_vs_model", {24'd0, data}, {24'd0, exp});
    end
  endtask

  task automatic send0(input logic [7:0] addr, input logic [7:0] wdata, output int acc);
    logic ok = 1'b0;
    logic rdy;
    z_cmd_valid = 1'b1; z_cmd_we = 1'b1; z_cmd_addr = addr; z_cmd_wdata = wdata;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk); rdy = z_cmd_ready;
      @(posedge clk); if (rdy) ok = 1'b1;
    end
    #1;
    acc = cyc;
    z_cmd_valid = 1'b0;
    chk("ta0_cmd_accept", {31'd0, ok}, 32'd1);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    int         hold;
  } vec_t;

  vec_t tab [11];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    int         acc, rel;
    int         accs [4];
    logic [7:0] d;

    tab[0]  = '{1'b1, 8'h00, 8'h00, 8'h00, 0};
    tab[1]  = '{1'b1, 8'hFF, 8'hFF, 8'h00, 0};
    tab[2]  = '{1'b1, 8'h80, 8'h5A, 8'h00, 0};
    tab[3]  = '{1'b0, 8'hFF, 8'h00, 8'hFF, 0};
    tab[4]  = '{1'b0, 8'h00, 8'h00, 8'h00, 2};
    tab[5]  = '{1'b1, 8'h00, 8'hA5, 8'h00, 0};
    tab[6]  = '{1'b0, 8'h00, 8'h00, 8'hA5, 1};
    tab[7]  = '{1'b0, 8'h80, 8'h00, 8'h5A, 0};
    tab[8]  = '{1'b0, 8'h10, 8'h00, 8'h3C, 3};
    tab[9]  = '{1'b1, 8'h7F, 8'h81, 8'h00, 0};
    tab[10] = '{1'b0, 8'h7F, 8'h00, 8'h81, 0};

    for (int i = 0; i < 256; i++) begin
      ram1[i] = 8'($urandom);
      ref_mem[i] = ram1[i];
      ram0[i] = 8'($urandom);
    end
    ram1[8'h20] = 8'hA5;
    ref_mem[8'h20] = 8'hA5;

    // Reset held two cycles with a write already offered.
    rst = 1'b1; rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 8'h10; cmd_wdata = 8'h3C;
    z_cmd_valid = 1'b0; z_cmd_we = 1'b0; z_cmd_addr = 8'h00; z_cmd_wdata = 8'h00;
    z_rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_bus_we", {31'd0, bus_we}, 32'd0);
      chk("rst_bus_oe", {31'd0, bus_oe}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_bus_addr", {24'd0, bus_addr}, 32'd0);
      chk("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
      chk("rst_bus_released", {24'd0, bus_data}, {24'd0, probe1});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    rel = cyc;
    mon_en = 1'b1;

    // First accept one cycle after reset drops; this is the 0x3C@0x10 write.
    send_cmd(1'b1, 8'h10, 8'h3C, acc);
    chk("first_accept_cycle", acc, rel + 1);
    @(negedge clk);
    chk("wr_bus_we", {31'd0, bus_we}, 32'd1);
    chk("wr_bus_oe", {31'd0, bus_oe}, 32'd0);
    chk("wr_bus_addr", {24'd0, bus_addr}, 32'h10);
    chk("wr_bus_data", {24'd0, bus_data}, 32'h3C);
    chk("wr_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk); #1;
    chk("wr_ram_updated", {24'd0, ram1[8'h10]}, 32'h3C);
    @(negedge clk);
    chk("turn_bus_we", {31'd0, bus_we}, 32'd0);
    chk("turn_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("turn_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;

    // Read back 0x10: rsp_valid exactly one cycle after the handshake.
    send_cmd(1'b0, 8'h10, 8'h00, acc);
    @(negedge clk);
    chk("rd_bus_oe", {31'd0, bus_oe}, 32'd1);
    chk("rd_bus_addr", {24'd0, bus_addr}, 32'h10);
    chk("rd_rsp_valid_early", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rd_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rd_rsp_rdata", {24'd0, rsp_rdata}, 32'h3C);
    @(posedge clk); #1;
    recv_rsp(0, d);

    // Table of directed vectors, including address/data extremes.
    foreach (tab[i]) begin
      send_cmd(tab[i].we, tab[i].addr, tab[i].wdata, acc);
      if (!tab[i].we) begin
        recv_rsp(tab[i].hold, d);
        chk("tab_rdata", {24'd0, d}, {24'd0, tab[i].exp_rdata});
      end
    end

    // Backpressure: five cycles of rsp_ready=0, handshake on the sixth.
    send_cmd(1'b0, 8'h20, 8'h00, acc);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rsp_rdata", {24'd0, rsp_rdata}, 32'hA5);
      chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_rsp_valid_last", {31'd0, rsp_valid}, 32'd1);
    d = rsp_rdata;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("bp_rdata_vs_model", {24'd0, d}, {24'd0, exp_q.pop_front()});
    @(negedge clk);
    chk("bp_turn_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp_turn_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;

    // Back-to-back writes with cmd_valid held, TURNAROUND=1.
    for (int i = 0; i < 4; i++) send_cmd(1'b1, 8'(i), 8'(8'h11 * (i + 1)), accs[i]);
    for (int i = 1; i < 4; i++) chk("b2b_ta1_spacing", accs[i] - accs[i-1], 32'd3);
    repeat (3) @(posedge clk); #1;
    for (int i = 0; i < 4; i++) chk("b2b_ta1_ram", {24'd0, ram1[i]}, 32'(8'h11 * (i + 1)));

    // Back-to-back writes with cmd_valid held, TURNAROUND=0.
    for (int i = 0; i < 4; i++) send0(8'(i), 8'(8'h11 * (i + 1)), accs[i]);
    for (int i = 1; i < 4; i++) chk("b2b_ta0_spacing", accs[i] - accs[i-1], 32'd2);
    repeat (3) @(posedge clk); #1;
    for (int i = 0; i < 4; i++) chk("b2b_ta0_ram", {24'd0, ram0[i]}, 32'(8'h11 * (i + 1)));

    // Reset during a pending response discards it.
    send_cmd(1'b0, 8'h02, 8'h00, acc);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rr_rsp_pending", {31'd0, rsp_valid}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("rr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rr_busy", {31'd0, busy}, 32'd0);
    chk("rr_bus_we", {31'd0, bus_we}, 32'd0);
    chk("rr_bus_oe", {31'd0, bus_oe}, 32'd0);
    chk("rr_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rr_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
    @(posedge clk); #1;

    // Randomized mixed traffic against the reference memory.
    for (int n = 0; n < 200; n++) begin
      logic       we;
      logic [7:0] addr;
      we   = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      send_cmd(we, addr, 8'($urandom), acc);
      if (!we) recv_rsp($urandom_range(0, 3), d);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (4) @(posedge clk); #1;
    mon_en = 1'b0;
    chk("exp_q_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_master.md
Name: mem_bus_master

Overview:
Initiator side of the shared 8-bit memory bus (tristate data, we/oe strobes, 8-bit address) used by the RAM.
- Accepts single read/write commands from the core over a valid/ready command port.
- Sequences bus_we/bus_oe/bus_addr, drives bus_data only during write cycles and captures read data.
- Returns read data over a valid/ready response port.
- Enforces bus turnaround so the master and the RAM never drive bus_data in the same cycle.

Parameters:
TURNAROUND, 1, idle cycles inserted after every bus access (we=oe=0, bus released); legal 0..3

Ports:
clk  input  1  system clock; all state updates on posedge
rst  input  1  synchronous active-high reset
cmd_valid  input  1  command offered
cmd_ready  output  1  command accepted this cycle when cmd_valid&cmd_ready
cmd_we  input  1  1 = write, 0 = read
cmd_addr  input  8  target address
cmd_wdata  input  8  write data; ignored for reads
rsp_valid  output  1  read data available
rsp_ready  input  1  consumer takes read data
rsp_rdata  output  8  captured read data
busy  output  1  high in every state except IDLE
bus_data  inout  8  shared data bus; driven only in WR, else 8'bz
bus_we  output  1  write strobe to RAM
bus_oe  output  1  output enable to RAM
bus_addr  output  8  address to RAM

Behaviour:
- Reset, effective at the posedge where rst=1:
  - state=IDLE.
  - bus_we=0, bus_oe=0, bus_addr=0, bus_data=z.
  - rsp_valid=0, rsp_rdata=0, busy=0.
  - Turn counter=0.
  - rst overrides every state, including mid-WR and RSP. A pending response is discarded.
  - A WR cycle in progress at the reset edge completes its RAM write at that edge, because the RAM samples the same edge. This is expected behaviour.
- States: IDLE, WR, RD, RSP, TURN.
- IDLE:
  - cmd_ready=1; the only state with cmd_ready high.
  - On cmd_valid: latch addr, we and wdata. Go to WR if cmd_we=1, else RD.
  - bus_addr holds its last value; bus_we=bus_oe=0.
- WR, exactly 1 cycle:
  - bus_we=1, bus_oe=0, bus_addr=latched addr, bus_data=latched wdata.
  - RAM captures at the closing edge.
  - Next state: TURN if TURNAROUND>0, else IDLE.
  - Writes produce no response.
- RD, exactly 1 cycle:
  - bus_oe=1, bus_we=0, bus_addr=latched addr, bus_data released.
  - bus_data is sampled into rsp_rdata at the closing edge; rsp_valid=1 from that edge. Next state RSP.
- RSP:
  - bus_we=bus_oe=0; rsp_valid=1; rsp_rdata stable.
  - On rsp_ready: rsp_valid=0 at that edge. Next state TURN if TURNAROUND>0, else IDLE.
  - rsp_ready may already be high on the first RSP cycle.
- TURN:
  - Lasts TURNAROUND cycles; bus_we=bus_oe=0; bus released; bus_addr held.
  - Then IDLE.
- Latency, with command handshake at edge N:
  - Write: RAM updated at edge N+1; next cmd_ready at cycle N+1+TURNAROUND.
  - Read: rsp_valid high from edge N+1.
- Throughput with cmd_valid held continuously: one write per 2+TURNAROUND cycles.
- Invariants:
  - bus_we & bus_oe never both 1.
  - bus_data is non-z only when bus_we=1.
  - cmd_ready & rsp_valid never both 1.
- Commands offered while busy are not accepted.
- The core holds cmd_* stable while cmd_valid & !cmd_ready.
- Address is plain 8-bit; no auto-increment or wrap logic.

Test Plan:
1. Reset: rst=1 for 2 cycles with cmd_valid=1 -> after the edge, bus_we=bus_oe=0, bus_data=z, rsp_valid=0, busy=0; first accept on the cycle after rst drops.
2. Write-then-read (TURNAROUND=1): write 0x3C@0x10, then read 0x10 -> WR cycle shows bus_we=1, bus_addr=0x10, bus_data=0x3C; rsp_valid exactly 1 cycle after the read handshake with rsp_rdata=0x3C.
3. Backpressure: read 0x20 (preloaded 0xA5) with rsp_ready=0 for 5 cycles -> rsp_valid held, rsp_rdata=0xA5 stable, cmd_ready=0 throughout; handshake on the 6th cycle, then TURN, then IDLE.
4. Back-to-back: cmd_valid held, writes 0x11,0x22,0x33,0x44 to 0x00..0x03 -> one write every 3 cycles (TURNAROUND=1), every 2 cycles (TURNAROUND=0); RAM contents match; bus_data=z outside WR.
5. Reset mid-response: assert rst during RSP -> rsp_valid=0 after the edge, state IDLE, bus released, no spurious bus_we.
6. Bus protocol monitor across randomized mixed reads/writes (200 commands): bus_we&bus_oe never both 1; no X on bus_data during RD; read-back matches a reference memory model.
